// File: rtl/mem_access_unit.sv
// Data-memory initiator: one load or store at a time over valid/ready, with a
// registered setup/strobe/hold sequence on the level-sensitive write strobe.
module mem_access_unit #(
   parameter int unsigned DATA_ADDRESS_WIDTH = 8,
   parameter int unsigned DATA_WIDTH         = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_we,
   input  logic [DATA_ADDRESS_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]         req_wdata,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          store_done,
   output logic                          busy,
   output logic [DATA_ADDRESS_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]         mem_wdata,
   input  logic [DATA_WIDTH-1:0]         mem_rdata,
   output logic                          mem_MW
);

   typedef enum logic [2:0] {
      IDLE,
      ST_SETUP,
      ST_WRITE,
      ST_HOLD,
      LD_READ,
      LD_RESP
   } state_e;

   state_e                        state_q, state_d;
   logic [DATA_ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]         wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]         rdata_q, rdata_d;
   logic                          mw_q, mw_d;
   logic                          done_q, done_d;
   logic                          rvalid_q, rvalid_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         mw_q     <= 1'b0;
         done_q   <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         mw_q     <= mw_d;
         done_q   <= done_d;
         rvalid_q <= rvalid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d = req_addr;
               if (req_we) begin
                  wdata_d = req_wdata;
                  state_d = ST_SETUP;
               end else begin
                  state_d = LD_READ;
               end
            end
         end
         ST_SETUP: state_d = ST_WRITE;
         ST_WRITE: state_d = ST_HOLD;
         ST_HOLD:  state_d = IDLE;
         LD_READ: begin
            rdata_d = mem_rdata;
            state_d = LD_RESP;
         end
         LD_RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobe/status flops are decoded from the next state so they toggle
   // together with the state register and never glitch.
   always_comb begin
      mw_d     = (state_d == ST_WRITE);
      done_d   = (state_d == ST_HOLD);
      rvalid_d = (state_d == LD_RESP);
   end

   assign req_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign mem_address = addr_q;
   assign mem_wdata   = wdata_q;
   assign mem_MW      = mw_q;
   assign store_done  = done_q;
   assign rsp_valid   = rvalid_q;
   assign rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against a behavioural
// data memory and a reference copy of its contents.
module tb_mem_access_unit;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          store_done;
   logic          busy;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_MW;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem     [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];

   always #5 clk = ~clk;

   mem_access_unit #(.DATA_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .store_done(store_done), .busy(busy),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_MW(mem_MW)
   );

   // Behavioural data memory: asynchronous read, write while MW is high.
   assign mem_rdata = mem[mem_address];
   always @(posedge clk) if (mem_MW) mem[mem_address] <= mem_wdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_idle();
      chk("idle_req_ready", {31'd0, req_ready}, 1);
      chk("idle_busy", {31'd0, busy}, 0);
      chk("idle_mw", {31'd0, mem_MW}, 0);
      chk("idle_rsp_valid", {31'd0, rsp_valid}, 0);
      chk("idle_store_done", {31'd0, store_done}, 0);
   endtask

   // Called at a negedge with the unit idle; returns at the negedge after
   // the unit is back in IDLE, ready for the next back-to-back request.
   task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
      chk("st_accept_ready", {31'd0, req_ready}, 1);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0; req_addr = ~a; req_wdata = ~d;
      chk("st_setup_mw", {31'd0, mem_MW}, 0);
      chk("st_setup_busy", {31'd0, busy}, 1);
      chk("st_setup_ready", {31'd0, req_ready}, 0);
      chk("st_setup_addr", {24'd0, mem_address}, {24'd0, a});
      chk("st_setup_data", {24'd0, mem_wdata}, {24'd0, d});
      @(negedge clk);
      req_valid = 1'b1;
      chk("st_write_mw", {31'd0, mem_MW}, 1);
      chk("st_write_done", {31'd0, store_done}, 0);
      chk("st_write_addr", {24'd0, mem_address}, {24'd0, a});
      chk("st_write_data", {24'd0, mem_wdata}, {24'd0, d});
      @(negedge clk);
      req_valid = 1'b0;
      chk("st_hold_mw", {31'd0, mem_MW}, 0);
      chk("st_hold_done", {31'd0, store_done}, 1);
      chk("st_hold_addr", {24'd0, mem_address}, {24'd0, a});
      chk("st_hold_data", {24'd0, mem_wdata}, {24'd0, d});
      chk("st_hold_ready", {31'd0, req_ready}, 0);
      @(negedge clk);
      chk_idle();
      chk("st_mem_content", {24'd0, mem[a]}, {24'd0, d});
      ref_mem[a] = d;
   endtask

   task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int stall);
      chk("ld_accept_ready", {31'd0, req_ready}, 1);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'h00;
      rsp_ready = 1'b0;
      @(negedge clk);
      req_addr = ~a; req_we = 1'b1;
      chk("ld_read_valid", {31'd0, rsp_valid}, 0);
      chk("ld_read_busy", {31'd0, busy}, 1);
      chk("ld_read_ready", {31'd0, req_ready}, 0);
      chk("ld_read_addr", {24'd0, mem_address}, {24'd0, a});
      chk("ld_read_mw", {31'd0, mem_MW}, 0);
      @(negedge clk);
      chk("ld_resp_valid", {31'd0, rsp_valid}, 1);
      chk("ld_resp_data", {24'd0, rsp_rdata}, {24'd0, exp});
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("ld_stall_valid", {31'd0, rsp_valid}, 1);
         chk("ld_stall_data", {24'd0, rsp_rdata}, {24'd0, exp});
         chk("ld_stall_ready", {31'd0, req_ready}, 0);
         chk("ld_stall_mw", {31'd0, mem_MW}, 0);
      end
      // Request still asserted at the handshake edge: must not be taken.
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; rsp_ready = 1'b0;
      chk_idle();
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
      int            stall;
   } vec_t;

   vec_t vecs [10];

   initial begin
      vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8'h00, 0};
      vecs[1] = '{1'b0, 8'h3C, 8'h00, 8'hA5, 0};
      vecs[2] = '{1'b1, 8'hFF, 8'hC3, 8'h00, 0};
      vecs[3] = '{1'b0, 8'hFF, 8'h00, 8'hC3, 5};
      vecs[4] = '{1'b1, 8'h00, 8'h5E, 8'h00, 0};
      vecs[5] = '{1'b0, 8'h00, 8'h00, 8'h5E, 0};
      vecs[6] = '{1'b0, 8'hFF, 8'h00, 8'hC3, 1};
      vecs[7] = '{1'b1, 8'h3C, 8'h00, 8'h00, 0};
      vecs[8] = '{1'b0, 8'h3C, 8'h00, 8'h00, 2};
      vecs[9] = '{1'b0, 8'h01, 8'h00, 8'h00, 0};

      for (int i = 0; i < (1 << AW); i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("rst_mw", {31'd0, mem_MW}, 0);
      chk("rst_addr", {24'd0, mem_address}, 0);
      chk("rst_wdata", {24'd0, mem_wdata}, 0);
      chk("rst_rdata", {24'd0, rsp_rdata}, 0);
      chk("rst_valid", {31'd0, rsp_valid}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle();

      // Reset in the middle of the write strobe.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'h5A;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("rw_mw_before", {31'd0, mem_MW}, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rw_mw_async", {31'd0, mem_MW}, 0);
      chk("rw_busy_async", {31'd0, busy}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle();
      chk("rw_addr", {24'd0, mem_address}, 0);
      chk("rw_wdata", {24'd0, mem_wdata}, 0);
      chk("rw_rdata", {24'd0, rsp_rdata}, 0);

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].we) do_store(vecs[i].addr, vecs[i].wdata);
         else            do_load(vecs[i].addr, vecs[i].exp, vecs[i].stall);
      end

      for (int i = 0; i < 200; i++) begin
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         a = AW'($urandom_range(0, (1 << AW) - 1));
         d = DW'($urandom_range(0, (1 << DW) - 1));
         if ($urandom_range(0, 1) == 1) do_store(a, d);
         else                           do_load(a, ref_mem[a], int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
